piso_serializer: RTL
====================

Name: piso_serializer

Overview:
Parallel-in serial-out transmitter. It is the driving end of the team's serial shift-register links. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock on a single serial line, with framing strobes. Its output feeds SISO/SIPO receive chains directly, so a stream of words produces a gap-free bit stream.

Parameters:
WIDTH, 8, data word width in bits; legal range is 2 or more.
LSB_FIRST, 0, bit order: 0 sends the MSB first, 1 sends the LSB first.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
din  input  WIDTH  parallel word to transmit.
din_valid  input  1  din holds a word to send.
din_ready  output  1  block can accept a word this cycle.
sout  output  1  serial data bit.
sout_valid  output  1  sout carries a frame bit this cycle.
sout_first  output  1  current bit is the first bit of the frame.
sout_last  output  1  current bit is the last bit of the frame.
busy  output  1  a frame is in progress; equal to sout_valid.

Behaviour:
- Reset and clocking are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values (immediate on rst_n=0, independent of clk):
  - state=IDLE, shift register=0, bit counter=0.
  - sout=0, sout_valid=0, sout_first=0, sout_last=0, busy=0.
  - din_ready goes to 1 once rst_n is released.
- FSM states:
  - IDLE: sout_valid=0 and sout=0. Accept fires when din_valid=1 and din_ready=1 at a rising edge. On accept: load din into the shift register, set counter=0, go to SHIFT.
  - SHIFT: sout_valid=1 and sout = the current head bit (din[WIDTH-1-n] when LSB_FIRST=0, din[n] when LSB_FIRST=1). Each edge advances the shift register and increments the counter.
  - Leaving SHIFT: on the edge that ends the last bit, go to IDLE unless a new accept fires on that same edge. In that case reload and stay in SHIFT with counter=0.
- Frame length is FLEN = WIDTH data bits (WIDTH+1 with the optional feature enabled).
- Framing strobes: sout_first=1 only when counter=0; sout_last=1 only when counter=FLEN-1.
- Latency: a word accepted on edge k puts bit 0 on sout in the cycle after edge k. The last bit appears in the cycle after edge k+FLEN-1.
- din_ready = (state==IDLE) or (state==SHIFT and counter==FLEN-1). It is combinational from state, so consecutive words stream with zero idle cycles.
- During SHIFT with counter<FLEN-1: din_ready=0, and din/din_valid are ignored. Data in flight is never corrupted.
- din is sampled only on the accept edge. It need not be held stable afterwards.
- Counter width is clog2(FLEN+1) bits. It never exceeds FLEN-1 and wraps to 0 only on reload.
- Reset mid-frame: the frame is abandoned and all outputs return immediately to their reset values. No partial frame resumes after rst_n is released.
- All outputs except din_ready are driven from registers (no combinational path from din to sout).

Optional Feature:
Macro: PISO_PARITY_EN.
- When defined: one even-parity bit (XOR of all WIDTH data bits) is appended after the data bits, so FLEN=WIDTH+1. sout_last flags the parity bit, and din_ready rises during the parity-bit cycle.
- When undefined: no parity logic is generated, FLEN=WIDTH, and sout_last flags the final data bit.

Test Plan:
1. Reset check: assert rst_n=0 mid-simulation with din_valid=1. All outputs must be 0 asynchronously (before the next edge). After release: din_ready=1, sout_valid=0.
2. Single word, default parameters: din=8'hA5, one valid pulse. In the 8 cycles that follow: sout = 1,0,1,0,0,1,0,1; sout_valid=1 throughout; sout_first only on cycle 1; sout_last only on cycle 8. Afterwards sout_valid=0 and din_ready=1.
3. Back-to-back streaming: din_valid held at 1 with 8'hA5 then 8'h3C. Expect 16 consecutive valid bits 10100101 00111100 with no gap. din_ready pulses on the last bit of the first word.
4. Ignored input: drive din=8'hFF, din_valid=1 during bit 3 of an 8'h00 frame. din_ready=0 in that cycle and the frame still outputs 8 zeros. 8'hFF starts on the cycle after the last bit.
5. Bit order: LSB_FIRST=1 with din=8'h1E must give sout = 0,1,1,1,1,0,0,0.
6. Parity with PISO_PARITY_EN defined:
   - 8'hA5 gives 9 bits ending in parity 0, with sout_last on bit 9.
   - 8'h07 gives a trailing parity bit of 1.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word over valid/ready and shifts
// it out one bit per clock with first/last strobes. Optional parity bit via PISO_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned FLEN = WIDTH + 1;
`else
  localparam int unsigned FLEN = WIDTH;
`endif
  localparam int unsigned CW = $clog2(FLEN + 1);
  localparam logic [CW-1:0] LastCnt = CW'(FLEN - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [FLEN-1:0] shift_q, shift_d, frame, shifted;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_q, first_d, last_q, last_d;
  logic            accept;

  // Frame word is laid out so the head bit sits at the end the register shifts out of.
  always_comb begin
`ifdef PISO_PARITY_EN
    if (LSB_FIRST != 0) frame = {^din, din};
    else                frame = {din, ^din};
`else
    frame = din;
`endif
    if (LSB_FIRST != 0) shifted = {1'b0, shift_q[FLEN-1:1]};
    else                shifted = {shift_q[FLEN-2:0], 1'b0};
  end

  // last_q is only ever set in StShift at the final count, so it stands in for that compare.
  assign din_ready = rst_n && ((state_q == StIdle) || last_q);
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StShift;
          shift_d = frame;
          cnt_d   = '0;
        end
      end
      StShift: begin
        if (last_q) begin
          if (accept) begin
            shift_d = frame;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
            shift_d = '0;
            cnt_d   = '0;
          end
        end else begin
          shift_d = shifted;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        shift_d = '0;
        cnt_d   = '0;
      end
    endcase
    first_d = (state_d == StShift) && (cnt_d == '0);
    last_d  = (state_d == StShift) && (cnt_d == LastCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // Shift register is cleared on leaving StShift, so the head bit is 0 while idle.
  assign sout       = (LSB_FIRST != 0) ? shift_q[0] : shift_q[FLEN-1];
  assign sout_valid = (state_q == StShift);
  assign busy       = sout_valid;
  assign sout_first = first_q;
  assign sout_last  = last_q;

endmodule
